// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding bytes from four requesters to a UART transmitter,
// with a per-frame watchdog that abandons a frame the UART never completes.
module uart_tx_scheduler #(
    parameter int TIMEOUT = 4095,
    parameter int NREQ    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     ack,
    output logic                uart_start,
    output logic [10:0]         uart_frame,
    input  logic                uart_busy,
    output logic [1:0]          owner,
    output logic                sched_busy,
    output logic                err_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    pick;
    logic [1:0]    idx;
    logic          found;

    // Search starts one past the last owner so a lone requester still wins every time.
    always_comb begin
        pick  = owner;
        idx   = owner;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = owner + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 2'd3;
            ack         <= '0;
            uart_start  <= 1'b0;
            err_timeout <= 1'b0;
            sched_busy  <= 1'b0;
            uart_frame  <= '1;
            count       <= '0;
        end else begin
            ack         <= '0;
            uart_start  <= 1'b0;
            err_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        owner      <= pick;
                        uart_frame <= {2'b11, req_data[8*pick +: 8], 1'b0};
                        ack        <= NREQ'(1) << pick;
                        state      <= LOAD;
                        sched_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    uart_start <= 1'b1;
                    count      <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    // The watchdog wins over a busy edge arriving on the same cycle.
                    if (count == LAST) begin
                        count       <= CW'(TIMEOUT);
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                        sched_busy  <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                        if (state == WAIT_BUSY && uart_busy) begin
                            state <= WAIT_DONE;
                        end else if (state == WAIT_DONE && !uart_busy) begin
                            state      <= IDLE;
                            sched_busy <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a frame-level schedule model predicts every output
// each cycle, while directed scenarios pin the model with literal expectations.
module tb_uart_tx_scheduler;

    localparam int T   = 16;
    localparam int INF = 1 << 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        uart_start;
    logic [10:0] uart_frame;
    logic        uart_busy;
    logic [1:0]  owner;
    logic        sched_busy;
    logic        err_timeout;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.TIMEOUT(T), .NREQ(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .uart_start(uart_start), .uart_frame(uart_frame), .uart_busy(uart_busy),
        .owner(owner), .sched_busy(sched_busy), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stimulus intent for the next cycle
    logic        rst_i;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    int          nd, nl;
    bit          rand_busy;

    // schedule model: cycle numbers of predicted events
    int          m_free, ack_at, start_at, err_at, busy_lo, busy_hi;
    logic [3:0]  ack_val;
    logic [1:0]  m_owner;
    logic [10:0] m_frame;

    // DUT observations used by the directed checks
    logic [3:0]  ack_log[$];
    int          n_ack, n_start, last_start, last_err;
    logic        busy_at_err;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endfunction

    task automatic grant();
        int w, s, d, l, e;
        bit found;
        w = int'(m_owner);
        found = 0;
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (int'(m_owner) + k) % 4;
            if (!found && req_i[j]) begin
                w = j;
                found = 1;
            end
        end
        d = nd;
        l = nl;
        if (rand_busy) begin
            d = int'($urandom_range(4)) - 1;
            l = int'($urandom_range(6, 1));
            if (d < 0 && l < 2) l = 2;
            if ($urandom_range(19) == 0) d = INF;
            else if ($urandom_range(19) == 0) l = INF;
        end
        m_owner  = 2'(w);
        m_frame  = {2'b11, data_i[8*w +: 8], 1'b0};
        ack_at   = cyc + 1;
        ack_val  = 4'(1 << w);
        s        = cyc + 2;
        start_at = s;
        busy_lo  = s + d;
        busy_hi  = (d >= INF || l >= INF) ? INF : s + d + l;
        e        = d + l;
        if (e >= T - 1) begin
            err_at = s + T;
            m_free = s + T;
            if (busy_hi > s + T) busy_hi = s + T;
        end else begin
            m_free = s + e + 1;
        end
        req_i[w] = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        chk("ack", 32'(ack), (cyc == ack_at) ? 32'(ack_val) : 32'd0);
        chk("uart_start", 32'(uart_start), 32'(cyc == start_at));
        chk("err_timeout", 32'(err_timeout), 32'(cyc == err_at));
        chk("sched_busy", 32'(sched_busy), 32'(cyc < m_free));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("uart_frame", 32'(uart_frame), 32'(m_frame));
        if (ack != 4'b0) begin
            ack_log.push_back(ack);
            n_ack++;
        end
        if (uart_start) begin
            n_start++;
            last_start = cyc;
        end
        if (err_timeout) begin
            last_err = cyc;
            busy_at_err = sched_busy;
        end
        reset     = rst_i;
        req       = req_i;
        req_data  = data_i;
        uart_busy = (cyc >= busy_lo && cyc < busy_hi);
        if (rst_i) begin
            m_free = cyc + 1; m_owner = 2'd3; m_frame = '1;
            ack_at = -1; start_at = -1; err_at = -1; busy_lo = INF; busy_hi = INF;
        end else if (cyc >= m_free && req_i != 4'b0) begin
            grant();
        end
        cyc++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cyc <= m_free && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_idle cyc=%0d got=busy want=idle", cyc);
        end
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_order[5];
        reset = 1'b1; req = '0; req_data = '0; uart_busy = 1'b0;
        rst_i = 1'b1; req_i = '0; data_i = '0; nd = 0; nl = 1; rand_busy = 0;
        m_free = 0; ack_at = -1; start_at = -1; err_at = -1; busy_lo = INF; busy_hi = INF;
        ack_val = '0; m_owner = 2'd3; m_frame = '1;
        n_ack = 0; n_start = 0; last_start = -1; last_err = -1; busy_at_err = 1'bx;

        // reset state
        step(); step();
        chk("rst_busy", 32'(sched_busy), 32'd0);
        chk("rst_frame", 32'(uart_frame), 32'h7FF);
        chk("rst_owner", 32'(owner), 32'd3);
        rst_i = 1'b0;

        // single byte A5 from requester 0
        req_i = 4'b0001; data_i = 32'h0000_00A5; nd = 0; nl = 3;
        step();
        step();
        chk("lit_ack", 32'(ack), 32'h1);
        step();
        chk("lit_start", 32'(uart_start), 32'd1);
        chk("lit_frame", 32'(uart_frame), 32'(11'b11_10100101_0));
        wait_idle();

        // all four held, UART busy 5 cycles per frame
        pulse_reset();
        ack_log.delete(); n_ack = 0; n_start = 0;
        nd = 0; nl = 5; data_i = 32'h4433_2211;
        for (int i = 0; i < 45; i++) begin
            req_i = 4'b1111;
            step();
        end
        req_i = '0;
        wait_idle();
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++)
            chk("rr_order", (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hDEAD, 32'(exp_order[i]));
        chk("start_eq_ack", 32'(n_start), 32'(n_ack));

        // UART never goes busy
        req_i = 4'b0010; nd = INF; nl = 1; last_err = -1;
        step();
        wait_idle();
        chk("timeout_gap0", 32'(last_err - last_start), 32'd16);
        req_i = 4'b1000; nd = 0; nl = 2; ack_log.delete();
        step();
        wait_idle();
        chk("after_timeout", (ack_log.size() > 0) ? 32'(ack_log[0]) : 32'hDEAD, 32'h8);

        // UART stuck busy
        req_i = 4'b0001; nd = 0; nl = INF; last_err = -1;
        step();
        wait_idle();
        chk("timeout_gap1", 32'(last_err - last_start), 32'd16);
        chk("busy_at_err", 32'(busy_at_err), 32'd0);

        // reset while in WAIT_DONE
        req_i = 4'b1010; data_i = 32'h5A00_C300; nd = 0; nl = 10;
        step();
        step(); step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        req_i = 4'b1100; ack_log.delete();
        step();
        chk("rst_mid_busy", 32'(sched_busy), 32'd0);
        chk("rst_mid_frame", 32'(uart_frame), 32'h7FF);
        step();
        chk("rst_first_grant", 32'(ack), 32'h4);
        wait_idle();

        // lone requester 2, repeated
        nd = 1; nl = 2;
        for (int r = 0; r < 3; r++) begin
            req_i = 4'b0100; data_i = $urandom;
            step();
            wait_idle();
            chk("lone_owner", 32'(owner), 32'd2);
        end

        // randomized traffic
        rand_busy = 1;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (!req_i[b]) begin
                    data_i[8*b +: 8] = 8'($urandom);
                    if ($urandom_range(3) == 0) req_i[b] = 1'b1;
                end
            end
            rst_i = ($urandom_range(299) == 0);
            step();
        end
        rst_i = 1'b0;
        req_i = '0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4095, meaning the maximum number of clk cycles spent waiting on the UART per frame.
REQ-002 SHALL have parameter NREQ, fixed at 4, meaning the number of requesters.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-requester send request, level, held until acked.
REQ-006 SHALL have port req_data  input  32  byte of requester i on bits [8i+7:8i].
REQ-007 SHALL have port ack  output  4  one-hot, one-cycle pulse: the requester's byte has been accepted.
REQ-008 SHALL have port uart_start  output  1  one-cycle pulse commanding the UART transmitter to send uart_frame.
REQ-009 SHALL have port uart_frame  output  11  frame: bit0 start (0), bits[8:1] data LSB first, bits[10:9] stop (11).
REQ-010 SHALL have port uart_busy  input  1  transmitter busy flag.
REQ-011 SHALL have port owner  output  2  index of the requester currently or last served.
REQ-012 SHALL have port sched_busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port err_timeout  output  1  one-cycle pulse when a frame is abandoned.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-015 SHALL, in IDLE with req!=0, select requester by round-robin starting at (owner+1) mod 4, register owner, register uart_frame={2'b11,byte,1'b0}, pulse ack[owner], and enter LOAD.
REQ-016 SHALL, in IDLE with req==0, remain in IDLE with all pulses low.
REQ-017 SHALL, in LOAD, pulse uart_start for exactly one cycle and enter WAIT_BUSY; the ack-to-uart_start latency is 1 cycle.
REQ-018 SHALL, in WAIT_BUSY, enter WAIT_DONE on the first cycle uart_busy=1.
REQ-019 SHALL, in WAIT_DONE, return to IDLE on the first cycle uart_busy=0.
REQ-020 SHALL clear the timeout counter on entry to WAIT_BUSY and increment it each cycle in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT it SHALL pulse err_timeout and go to IDLE. A requester whose frame times out is not re-acked.
REQ-021 SHALL hold uart_frame stable from LOAD until the next grant.
REQ-022 SHALL ignore req changes outside IDLE; the earliest next grant is the cycle after returning to IDLE, so the minimum grant spacing is 4 cycles.
REQ-023 SHALL give a lone requester back-to-back grants, with no starvation: each of 4 continuously requesting sources is granted once per 4 grants.
REQ-024 SHALL handle uart_busy already high in LOAD by still entering WAIT_BUSY; WAIT_BUSY then exits in 1 cycle.
REQ-025 SHALL size the timeout counter to ceil(log2(TIMEOUT+1)) bits with no wrap; it saturates at TIMEOUT only through the abort.

Reset
REQ-026 SHALL, on reset, set state=IDLE, owner=3 (so requester 0 has first priority), ack=0, uart_start=0, err_timeout=0, sched_busy=0, uart_frame=11'h7FF (idle line), and counter=0.
REQ-027 SHALL give reset priority over all FSM activity, including mid-frame; no pulse is emitted in the reset cycle or the cycle after it.

Verification
REQ-028 SHALL be verified by this scenario: req=4'b0001, byte0=8'hA5 -> ack=0001 next cycle; uart_start one cycle later with uart_frame=11'b11_10100101_0.
REQ-029 SHALL be verified by this scenario: req=4'b1111 held, with a UART model giving busy for 5 cycles -> ack order 0,1,2,3,0 and uart_start count equal to ack count.
REQ-030 SHALL be verified by this scenario: uart_busy stuck 0, TIMEOUT=16 -> err_timeout pulses 16 cycles after entering WAIT_BUSY; FSM back in IDLE; next req granted.
REQ-031 SHALL be verified by this scenario: uart_busy stuck 1 in WAIT_DONE, TIMEOUT=16 -> err_timeout pulses and sched_busy falls.
REQ-032 SHALL be verified by this scenario: reset asserted in WAIT_DONE -> next cycle sched_busy=0 and uart_frame=7FF; first grant after release goes to the lowest active index.
REQ-033 SHALL be verified by this scenario: req=4'b0100 only, repeated -> requester 2 granted every frame; owner stays 2.
